// File: rtl/spi_regbank.sv
// spi_regbank: SPI-slave register bank with oversampled SPI engine, burst auto-increment and live status
module spi_regbank #(
  parameter int NUM_CFG = 8,
  parameter int NUM_STATUS = 8,
  parameter int REG_WIDTH = 8,
  parameter logic [NUM_CFG*REG_WIDTH-1:0] CFG_RESET = '0
) (
  input  logic                             clk,
  input  logic                             rstb,
  input  logic                             ena,
  input  logic [1:0]                       mode,
  input  logic                             spi_cs_n,
  input  logic                             spi_clk,
  input  logic                             spi_mosi,
  output logic                             spi_miso,
  input  logic [NUM_STATUS*REG_WIDTH-1:0]  status_i,
  output logic [NUM_CFG*REG_WIDTH-1:0]     config_regs,
  output logic [NUM_CFG-1:0]               cfg_wr_stb,
  output logic [NUM_STATUS-1:0]            status_rd_stb
);
  localparam int W = REG_WIDTH;
  localparam int TOTAL = NUM_CFG + NUM_STATUS;
  typedef enum logic [1:0] {IDLE, CMD, DATA, WAIT_CS} state_t;
  state_t state_q, state_d;
  logic [1:0] cs_sync_q, cs_sync_d, mosi_sync_q, mosi_sync_d;
  logic [2:0] sck_sync_q, sck_sync_d;
  logic [4:0] cnt_q, cnt_d;
  logic [6:0] addr_q, addr_d;
  logic wr_q, wr_d, miso_q, miso_d;
  logic [W-2:0] rx_q, rx_d;
  logic [W-1:0] tx_q, tx_d;
  logic [NUM_CFG*W-1:0] cfg_q, cfg_d;
  logic [NUM_CFG-1:0] wstb_q, wstb_d;
  logic [NUM_STATUS-1:0] rdstb_q, rdstb_d, rd_hit;
  logic sck_rise, sck_fall, sample, shift, cs_hi, bit_in;
  logic [6:0] ld_addr, addr_inc;
  logic [7:0] cmd_word;
  logic [W-1:0] wr_word, rd_word;
  assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
  assign sck_fall = ~sck_sync_q[1] & sck_sync_q[2];
  assign sample = (mode[1] ^ mode[0]) ? sck_fall : sck_rise;
  assign shift = (mode[1] ^ mode[0]) ? sck_rise : sck_fall;
  assign cs_hi = cs_sync_q[1];
  assign bit_in = mosi_sync_q[1];
  assign cmd_word = {rx_q[6:0], bit_in};
  assign wr_word = {rx_q, bit_in};
  assign addr_inc = (addr_q == 7'(TOTAL-1)) ? '0 : addr_q + 7'd1;
  assign ld_addr = (state_q == CMD) ? cmd_word[6:0] : addr_inc;
  assign spi_miso = miso_q & ena & ~spi_cs_n & (state_q == DATA);
  assign config_regs = cfg_q;
  assign cfg_wr_stb = wstb_q;
  assign status_rd_stb = rdstb_q;
  always_comb begin
    rd_word = '0;
    rd_hit = '0;
    for (int k = 0; k < NUM_CFG; k++)
      if (ld_addr == 7'(k)) rd_word = cfg_q[k*W +: W];
    for (int k = 0; k < NUM_STATUS; k++)
      if (ld_addr == 7'(NUM_CFG+k)) begin
        rd_word = status_i[k*W +: W];
        rd_hit[k] = 1'b1;
      end
  end
  always_comb begin
    cs_sync_d = {cs_sync_q[0], spi_cs_n};
    sck_sync_d = {sck_sync_q[1:0], spi_clk};
    mosi_sync_d = {mosi_sync_q[0], spi_mosi};
    state_d = state_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    wr_d = wr_q;
    rx_d = rx_q;
    tx_d = tx_q;
    miso_d = miso_q;
    cfg_d = cfg_q;
    wstb_d = '0;
    rdstb_d = '0;
    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        tx_d = '0;
        cnt_d = '0;
        if (!cs_hi) state_d = CMD;
      end
      CMD: begin
        miso_d = 1'b0;
        if (cs_hi) state_d = IDLE;
        else if (sample) begin
          rx_d = wr_word[W-2:0];
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd7) begin
            wr_d = cmd_word[7];
            addr_d = cmd_word[6:0];
            cnt_d = '0;
            state_d = DATA;
            if (!cmd_word[7]) begin
              tx_d = rd_word;
              rdstb_d = rd_hit;
            end
          end
        end
      end
      DATA: begin
        if (cs_hi) state_d = IDLE;
        else begin
          if (shift) begin
            miso_d = tx_q[W-1];
            tx_d = tx_q << 1;
          end
          if (sample) begin
            rx_d = wr_word[W-2:0];
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'(W-1)) begin
              cnt_d = '0;
              addr_d = addr_inc;
              if (wr_q) begin
                for (int k = 0; k < NUM_CFG; k++)
                  if (addr_q == 7'(k)) begin
                    cfg_d[k*W +: W] = wr_word;
                    wstb_d[k] = 1'b1;
                  end
              end else begin
                tx_d = rd_word;
                rdstb_d = rd_hit;
              end
            end
          end
        end
      end
      WAIT_CS: begin
        miso_d = 1'b0;
        if (cs_hi) state_d = IDLE;
      end
    endcase
    if (!ena) begin
      state_d = WAIT_CS;
      cfg_d = cfg_q;
      wstb_d = '0;
      rdstb_d = '0;
    end
  end
  // cs sync resets low so WAIT_CS only leaves on a genuinely observed high cs_n
  always_ff @(posedge clk or negedge rstb)
    if (!rstb) begin
      state_q <= WAIT_CS;
      cs_sync_q <= '0;
      sck_sync_q <= '0;
      mosi_sync_q <= '0;
      cnt_q <= '0;
      addr_q <= '0;
      wr_q <= 1'b0;
      rx_q <= '0;
      tx_q <= '0;
      miso_q <= 1'b0;
      cfg_q <= CFG_RESET;
      wstb_q <= '0;
      rdstb_q <= '0;
    end else begin
      state_q <= state_d;
      cs_sync_q <= cs_sync_d;
      sck_sync_q <= sck_sync_d;
      mosi_sync_q <= mosi_sync_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      wr_q <= wr_d;
      rx_q <= rx_d;
      tx_q <= tx_d;
      miso_q <= miso_d;
      cfg_q <= cfg_d;
      wstb_q <= wstb_d;
      rdstb_q <= rdstb_d;
    end
endmodule

// File: tb/tb_spi_regbank.sv
// tb_spi_regbank: randomized SPI master against an array-based register bank model
module tb_spi_regbank;
  localparam int NC = 8, NS = 8, W = 8, HALF = 5;
  localparam logic [NC*W-1:0] RST_IMG = 64'h0000_0000_0000_00A5;
  logic clk = 1'b0, rstb = 1'b0, ena = 1'b1, spi_cs_n = 1'b1, spi_clk = 1'b0, spi_mosi = 1'b0;
  logic spi_miso;
  logic [1:0] mode = 2'b00;
  logic [NS*W-1:0] status_i = '0;
  logic [NC*W-1:0] config_regs;
  logic [NC-1:0] cfg_wr_stb;
  logic [NS-1:0] status_rd_stb;
  int n_vec = 0, n_err = 0;
  int wcnt[NC], rcnt[NS], w0[NC], r0[NS], xw[NC], xs[NS];
  time wtime = 0, last_t = 0;
  logic [7:0] m_cfg[NC], mw[8], mr[8], xr[8];
  always #5 clk = ~clk;
  spi_regbank #(.NUM_CFG(NC), .NUM_STATUS(NS), .REG_WIDTH(W), .CFG_RESET(RST_IMG)) dut (
    .clk(clk), .rstb(rstb), .ena(ena), .mode(mode), .spi_cs_n(spi_cs_n), .spi_clk(spi_clk),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .status_i(status_i), .config_regs(config_regs),
    .cfg_wr_stb(cfg_wr_stb), .status_rd_stb(status_rd_stb)
  );
  always @(negedge clk) begin
    for (int k = 0; k < NC; k++) if (cfg_wr_stb[k]) wcnt[k] <= wcnt[k] + 1;
    for (int k = 0; k < NS; k++) if (status_rd_stb[k]) rcnt[k] <= rcnt[k] + 1;
    if (|cfg_wr_stb) wtime <= $time;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic half();
    repeat (HALF) @(negedge clk);
  endtask
  task automatic snap();
    for (int k = 0; k < NC; k++) begin w0[k] = wcnt[k]; xw[k] = 0; end
    for (int k = 0; k < NS; k++) begin r0[k] = rcnt[k]; xs[k] = 0; end
  endtask
  task automatic spi_frame(input logic [1:0] md, input logic [7:0] cmd, input int nw, input int ndb);
    logic bo;
    int d;
    for (int i = 0; i < 8; i++) mr[i] = 8'h00;
    mode = md;
    spi_clk = md[1];
    repeat (3) @(negedge clk);
    spi_cs_n = 1'b0;
    half();
    for (int b = 0; b < 8 + ndb; b++) begin
      d = b - 8;
      if (b < 8) bo = cmd[7-b];
      else bo = mw[d/8][7-d%8];
      if (!md[0]) begin
        spi_mosi = bo;
        half();
        spi_clk = ~md[1];
        last_t = $time;
        if (d >= 0 && d < nw*8) mr[d/8][7-d%8] = spi_miso;
        half();
        spi_clk = md[1];
      end else begin
        spi_clk = ~md[1];
        spi_mosi = bo;
        half();
        spi_clk = md[1];
        last_t = $time;
        if (d >= 0 && d < nw*8) mr[d/8][7-d%8] = spi_miso;
        half();
      end
    end
    half();
    spi_cs_n = 1'b1;
    repeat (2*HALF) @(negedge clk);
  endtask
  function automatic logic [7:0] ref_val(input int a);
    if (a < NC) return m_cfg[a];
    if (a < NC + NS) return status_i[(a-NC)*8 +: 8];
    return 8'h00;
  endfunction
  function automatic logic [NC*W-1:0] exp_cfg();
    logic [NC*W-1:0] r;
    for (int k = 0; k < NC; k++) r[k*W +: W] = m_cfg[k];
    return r;
  endfunction
  task automatic frame_model(input logic [1:0] md, input logic [7:0] cmd, input int nw);
    int a;
    snap();
    spi_frame(md, cmd, nw, nw*8);
    a = int'(cmd[6:0]);
    for (int i = 0; i <= nw; i++) begin
      if (cmd[7] && i < nw && a < NC) begin m_cfg[a] = mw[i]; xw[a]++; end
      if (!cmd[7]) begin
        if (i < nw) xr[i] = ref_val(a);
        if (a >= NC && a < NC + NS) xs[a-NC]++;
      end
      a = (a == NC + NS - 1) ? 0 : (a + 1) % 128;
    end
  endtask
  task automatic test_reset();
    logic [NC*W-1:0] img;
    img = RST_IMG;
    rstb = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < NC; k++) m_cfg[k] = img[k*W +: W];
    n_vec++; if (config_regs !== 64'hA5) begin n_err++; $display("FAIL reset_cfg: got %h expected %h", config_regs, 64'hA5); end
    n_vec++; if (spi_miso !== 1'b0) begin n_err++; $display("FAIL reset_miso: got %b expected 0", spi_miso); end
    n_vec++; if (cfg_wr_stb !== '0) begin n_err++; $display("FAIL reset_wstb: got %b expected 0", cfg_wr_stb); end
    n_vec++; if (status_rd_stb !== '0) begin n_err++; $display("FAIL reset_rstb: got %b expected 0", status_rd_stb); end
    rstb = 1'b1;
    repeat (5) @(negedge clk);
    n_vec++; if (spi_miso !== 1'b0) begin n_err++; $display("FAIL idle_miso: got %b expected 0", spi_miso); end
  endtask
  task automatic test_write_latency();
    mw[0] = 8'h3C;
    frame_model(2'b00, 8'h82, 1);
    n_vec++; if (config_regs[23:16] !== 8'h3C) begin n_err++; $display("FAIL wr_reg2: got %h expected 3c", config_regs[23:16]); end
    n_vec++; if (config_regs !== exp_cfg()) begin n_err++; $display("FAIL wr_cfg: got %h expected %h", config_regs, exp_cfg()); end
    for (int k = 0; k < NC; k++) begin
      n_vec++; if (wcnt[k] - w0[k] != xw[k]) begin n_err++; $display("FAIL wr_wstb[%0d]: got %0d expected %0d", k, wcnt[k] - w0[k], xw[k]); end
    end
    n_vec++; if (wtime - last_t != 30) begin n_err++; $display("FAIL wr_latency: got %0t expected 30", wtime - last_t); end
  endtask
  task automatic test_burst_read();
    mw[0] = 8'h5A;
    frame_model(2'b11, 8'h87, 1);
    status_i = {$urandom, $urandom};
    status_i[7:0] = 8'hCA;
    frame_model(2'b11, 8'h07, 2);
    n_vec++; if (mr[0] !== 8'h5A) begin n_err++; $display("FAIL brd_cfg7: got %h expected 5a", mr[0]); end
    n_vec++; if (mr[1] !== 8'hCA) begin n_err++; $display("FAIL brd_stat0: got %h expected ca", mr[1]); end
    for (int i = 0; i < 2; i++) begin
      n_vec++; if (mr[i] !== xr[i]) begin n_err++; $display("FAIL brd_word[%0d]: got %h expected %h", i, mr[i], xr[i]); end
    end
    n_vec++; if (rcnt[0] - r0[0] != 1) begin n_err++; $display("FAIL brd_rstb0: got %0d expected 1", rcnt[0] - r0[0]); end
    for (int k = 0; k < NS; k++) begin
      n_vec++; if (rcnt[k] - r0[k] != xs[k]) begin n_err++; $display("FAIL brd_rstb[%0d]: got %0d expected %0d", k, rcnt[k] - r0[k], xs[k]); end
    end
  endtask
  task automatic test_burst_wrap();
    for (int i = 0; i < 3; i++) mw[i] = 8'($urandom);
    frame_model(2'b00, 8'h8F, 3);
    n_vec++; if (config_regs !== exp_cfg()) begin n_err++; $display("FAIL wrap_cfg: got %h expected %h", config_regs, exp_cfg()); end
    for (int k = 0; k < NC; k++) begin
      n_vec++; if (wcnt[k] - w0[k] != ((k < 2) ? 1 : 0)) begin n_err++; $display("FAIL wrap_wstb[%0d]: got %0d expected %0d", k, wcnt[k] - w0[k], (k < 2) ? 1 : 0); end
    end
  endtask
  task automatic test_abort();
    for (int md = 0; md < 4; md++) begin
      mw[0] = 8'($urandom);
      snap();
      spi_frame(2'(md), 8'h84, 1, 5);
      n_vec++; if (config_regs !== exp_cfg()) begin n_err++; $display("FAIL abort_cfg m%0d: got %h expected %h", md, config_regs, exp_cfg()); end
      for (int k = 0; k < NC; k++) begin
        n_vec++; if (wcnt[k] != w0[k]) begin n_err++; $display("FAIL abort_wstb[%0d] m%0d: got %0d expected 0", k, md, wcnt[k] - w0[k]); end
      end
      frame_model(2'(md), 8'h84, 1);
      n_vec++; if (config_regs !== exp_cfg()) begin n_err++; $display("FAIL abort_next m%0d: got %h expected %h", md, config_regs, exp_cfg()); end
    end
  endtask
  task automatic test_rst_mid();
    logic [NC*W-1:0] img;
    img = RST_IMG;
    for (int md = 0; md < 4; md++) begin
      mw[0] = 8'($urandom);
      mw[1] = 8'($urandom);
      snap();
      fork
        spi_frame(2'(md), 8'h83, 2, 16);
        begin
          repeat (110) @(negedge clk);
          rstb = 1'b0;
          repeat (2) @(negedge clk);
          n_vec++; if (config_regs !== img) begin n_err++; $display("FAIL rst_now_cfg m%0d: got %h expected %h", md, config_regs, img); end
          n_vec++; if (spi_miso !== 1'b0) begin n_err++; $display("FAIL rst_now_miso m%0d: got %b expected 0", md, spi_miso); end
          rstb = 1'b1;
        end
      join
      for (int k = 0; k < NC; k++) m_cfg[k] = img[k*W +: W];
      n_vec++; if (config_regs !== exp_cfg()) begin n_err++; $display("FAIL rst_mid_cfg m%0d: got %h expected %h", md, config_regs, exp_cfg()); end
      for (int k = 0; k < NC; k++) begin
        n_vec++; if (wcnt[k] != w0[k]) begin n_err++; $display("FAIL rst_mid_wstb[%0d] m%0d: got %0d expected 0", k, md, wcnt[k] - w0[k]); end
      end
      frame_model(2'(md), 8'h83, 1);
      n_vec++; if (config_regs !== exp_cfg()) begin n_err++; $display("FAIL rst_next m%0d: got %h expected %h", md, config_regs, exp_cfg()); end
    end
  endtask
  task automatic test_ena();
    for (int md = 0; md < 4; md++) begin
      status_i = {$urandom, $urandom} | 64'hFFFF_0000;
      snap();
      fork
        spi_frame(2'(md), 8'h09, 2, 16);
        begin repeat (30) @(negedge clk); ena = 1'b0; end
      join
      ena = 1'b1;
      for (int i = 0; i < 2; i++) begin
        n_vec++; if (mr[i] !== 8'h00) begin n_err++; $display("FAIL ena_miso[%0d] m%0d: got %h expected 00", i, md, mr[i]); end
      end
      for (int k = 0; k < NS; k++) begin
        n_vec++; if (rcnt[k] != r0[k]) begin n_err++; $display("FAIL ena_rstb[%0d] m%0d: got %0d expected 0", k, md, rcnt[k] - r0[k]); end
      end
      mw[0] = 8'($urandom);
      ena = 1'b0;
      spi_frame(2'(md), 8'h85, 1, 8);
      ena = 1'b1;
      n_vec++; if (config_regs !== exp_cfg()) begin n_err++; $display("FAIL ena_cfg m%0d: got %h expected %h", md, config_regs, exp_cfg()); end
      for (int k = 0; k < NC; k++) begin
        n_vec++; if (wcnt[k] != w0[k]) begin n_err++; $display("FAIL ena_wstb[%0d] m%0d: got %0d expected 0", k, md, wcnt[k] - w0[k]); end
      end
    end
  endtask
  task automatic test_unmapped();
    for (int md = 0; md < 4; md++) begin
      frame_model(2'(md), 8'h7F, 2);
      n_vec++; if (mr[0] !== 8'h00) begin n_err++; $display("FAIL unmap_word m%0d: got %h expected 00", md, mr[0]); end
      n_vec++; if (mr[1] !== xr[1]) begin n_err++; $display("FAIL unmap_wrap m%0d: got %h expected %h", md, mr[1], xr[1]); end
      for (int k = 0; k < NS; k++) begin
        n_vec++; if (rcnt[k] - r0[k] != xs[k]) begin n_err++; $display("FAIL unmap_rstb[%0d] m%0d: got %0d expected %0d", k, md, rcnt[k] - r0[k], xs[k]); end
      end
    end
  endtask
  task automatic test_random();
    logic [6:0] a;
    logic wr;
    int nw;
    logic [1:0] md;
    for (int t = 0; t < 40; t++) begin
      md = 2'($urandom_range(0, 3));
      wr = 1'($urandom);
      a = ($urandom_range(0, 4) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 15));
      nw = $urandom_range(1, 4);
      for (int i = 0; i < 8; i++) mw[i] = 8'($urandom);
      status_i = {$urandom, $urandom};
      frame_model(md, {wr, a}, nw);
      n_vec++; if (config_regs !== exp_cfg()) begin n_err++; $display("FAIL rnd_cfg #%0d: got %h expected %h", t, config_regs, exp_cfg()); end
      if (!wr) for (int i = 0; i < nw; i++) begin
        n_vec++; if (mr[i] !== xr[i]) begin n_err++; $display("FAIL rnd_word[%0d] #%0d: got %h expected %h", i, t, mr[i], xr[i]); end
      end
      for (int k = 0; k < NC; k++) begin
        n_vec++; if (wcnt[k] - w0[k] != xw[k]) begin n_err++; $display("FAIL rnd_wstb[%0d] #%0d: got %0d expected %0d", k, t, wcnt[k] - w0[k], xw[k]); end
      end
      for (int k = 0; k < NS; k++) begin
        n_vec++; if (rcnt[k] - r0[k] != xs[k]) begin n_err++; $display("FAIL rnd_rstb[%0d] #%0d: got %0d expected %0d", k, t, rcnt[k] - r0[k], xs[k]); end
      end
    end
  endtask
  initial begin
    test_reset();
    test_write_latency();
    test_burst_read();
    test_burst_wrap();
    test_abort();
    test_rst_mid();
    test_ena();
    test_unmapped();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
